// File: rtl/vga_pkg.sv
// vga_pkg
// Shared VGA timing constants for 640x480 @ 60 Hz from a 100 MHz board clock.
// The timing, bitchange and game blocks all import this package so that they
// agree on the visible-region bounds. Also holds the counter type and a
// small range-decode helper.
package vga_pkg;

  localparam int COUNT_W     = 10;
  localparam int COUNT_LIMIT = 1 << COUNT_W;

  typedef logic [COUNT_W-1:0] count_t;

  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END   = 783;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END   = 514;

  // Inclusive range test used by the visible-region decode.
  function automatic logic in_span(count_t x, count_t lo, count_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Raster timing bundle from the timing generator to its consumers.
//   pix_en     : one-clk pixel-rate enable
//   hCount     : horizontal pixel counter
//   vCount     : vertical line counter
//   bright     : visible-region flag
//   hSync      : horizontal sync, active-low
//   vSync      : vertical sync, active-low
//   frame_tick : one-clk pulse at the frame wrap
// master = timing generator, slave = colour/game logic.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_en;
  count_t hCount;
  count_t vCount;
  logic   bright;
  logic   hSync;
  logic   vSync;
  logic   frame_tick;

  modport master (
    output pix_en, hCount, vCount, bright, hSync, vSync, frame_tick
  );

  modport slave (
    input pix_en, hCount, vCount, bright, hSync, vSync, frame_tick
  );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// clk_en_div
// Clock-enable divider: a free-running modulo-DIV counter.
//   clk    : system clock
//   rst    : asynchronous reset, active-low
//   en     : combinational, high in the last clk of each DIV-clk period
//   pix_en : registered copy of en, high for the one clk after en
// Reusable for slower ticks by raising DIV.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic en,
  output logic pix_en
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("clk_en_div: DIV must be at least 2");
  end

  logic [W-1:0] div;

  assign en = (div == LAST);

  // Wrap explicitly at DIV-1 so non-power-of-two dividers also work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= en ? '0 : div + 1'b1;
      pix_en <= en;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator: pixel/line counters plus registered sync,
// visible-region and frame-wrap decode, advancing at the pixel rate given by
// a clock enable derived from the single board clock.
//   clk : 100 MHz system clock
//   rst : asynchronous reset, active-low
//   vga : timing bundle (master side): pix_en, hCount, vCount, bright,
//         hSync, vSync, frame_tick
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END
) (
  input  logic clk,
  input  logic rst,
  vga_timing_gen_if.master vga
);

  if (H_TOTAL > COUNT_LIMIT || V_TOTAL > COUNT_LIMIT) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed %0d", COUNT_LIMIT);
  end

  localparam count_t H_LAST  = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST  = count_t'(V_TOTAL - 1);
  localparam count_t H_SYNC_C = count_t'(H_SYNC);
  localparam count_t V_SYNC_C = count_t'(V_SYNC);
  localparam count_t H_VS    = count_t'(H_VIS_START);
  localparam count_t H_VE    = count_t'(H_VIS_END);
  localparam count_t V_VS    = count_t'(V_VIS_START);
  localparam count_t V_VE    = count_t'(V_VIS_END);

  logic   en;
  logic   pix_en;
  count_t h_count;
  count_t v_count;
  count_t h_next;
  count_t v_next;
  logic   bright;
  logic   h_sync;
  logic   v_sync;
  logic   frame_tick;

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .pix_en (pix_en)
  );

  // Next-state counters; the decode below uses these so the registered
  // sync/bright outputs line up with the counts on the same edge.
  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (en) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end else begin
        h_next = h_count + 1'b1;
      end
    end
  end

  // Sync outputs reset low because count 0 lies inside both sync pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_count    <= '0;
      v_count    <= '0;
      bright     <= 1'b0;
      h_sync     <= 1'b0;
      v_sync     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      h_count    <= h_next;
      v_count    <= v_next;
      bright     <= in_span(h_next, H_VS, H_VE) && in_span(v_next, V_VS, V_VE);
      h_sync     <= (h_next >= H_SYNC_C);
      v_sync     <= (v_next >= V_SYNC_C);
      frame_tick <= en && (h_count == H_LAST) && (v_count == V_LAST);
    end
  end

  assign vga.pix_en     = pix_en;
  assign vga.hCount     = h_count;
  assign vga.vCount     = v_count;
  assign vga.bright     = bright;
  assign vga.hSync      = h_sync;
  assign vga.vSync      = v_sync;
  assign vga.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Two instances share clk/rst:
// one with the default 800x525 timing (line-level checks) and one with a
// shrunken raster (frame-level checks within a short run).
module tb_vga_timing_gen;

  localparam int DIV   = 4;
  localparam int D_HT  = 800, D_HS = 96, D_HVS = 144, D_HVE = 783;
  localparam int D_VT  = 525, D_VS = 2,  D_VVS = 35,  D_VVE = 514;
  localparam int S_HT  = 20,  S_HS = 3,  S_HVS = 5,   S_HVE = 16;
  localparam int S_VT  = 12,  S_VS = 2,  S_VVS = 3,   S_VVE = 9;
  localparam int S_FRAME = S_HT * S_VT * DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if ifD ();
  vga_timing_gen_if ifS ();

  vga_timing_gen dutD (
    .clk (clk),
    .rst (rst),
    .vga (ifD)
  );

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS),
    .H_VIS_END(S_HVE), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS),
    .V_VIS_END(S_VVE)
  ) dutS (
    .clk (clk),
    .rst (rst),
    .vga (ifS)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int errD = 0, errS = 0, alignD = 0, alignS = 0;

  typedef struct {
    int         h;
    int         v;
    logic [2:0] exp;
  } vec_t;

  vec_t defVecs[10];
  vec_t smallVecs[10];

  // Rising edges since the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [2:0] decodeSel(bit sel, int h, int v);
    logic b;
    if (sel) b = (h >= S_HVS) && (h <= S_HVE) && (v >= S_VVS) && (v <= S_VVE);
    else     b = (h >= D_HVS) && (h <= D_HVE) && (v >= D_VVS) && (v <= D_VVE);
    return {b, (h >= (sel ? S_HS : D_HS)), (v >= (sel ? S_VS : D_VS))};
  endfunction

  function automatic logic [24:0] modelVec(bit sel, int n);
    int ht, vt, idx, h, v;
    logic pe, ft;
    ht  = sel ? S_HT : D_HT;
    vt  = sel ? S_VT : D_VT;
    pe  = (n > 0) && (n % DIV == 0);
    idx = n / DIV;
    h   = idx % ht;
    v   = (idx / ht) % vt;
    ft  = pe && (h == 0) && (v == 0);
    return {pe, 10'(h), 10'(v), decodeSel(sel, h, v), ft};
  endfunction

  function automatic int curH(bit sel);
    return sel ? int'(ifS.hCount) : int'(ifD.hCount);
  endfunction

  function automatic int curV(bit sel);
    return sel ? int'(ifS.vCount) : int'(ifD.vCount);
  endfunction

  function automatic logic [2:0] curDec(bit sel);
    return sel ? {ifS.bright, ifS.hSync, ifS.vSync} : {ifD.bright, ifD.hSync, ifD.vSync};
  endfunction

  function automatic logic [24:0] dutVec(bit sel);
    if (sel)
      return {ifS.pix_en, ifS.hCount, ifS.vCount, ifS.bright, ifS.hSync, ifS.vSync, ifS.frame_tick};
    return {ifD.pix_en, ifD.hCount, ifD.vCount, ifD.bright, ifD.hSync, ifD.vSync, ifD.frame_tick};
  endfunction

  // Cycle-by-cycle comparison against the arithmetic raster model, plus the
  // zero-skew check of decoded outputs against the presented counts.
  always @(negedge clk) begin
    if (dutVec(1'b0) !== modelVec(1'b0, cyc)) errD++;
    if (dutVec(1'b1) !== modelVec(1'b1, cyc)) errS++;
    if (curDec(1'b0) !== decodeSel(1'b0, curH(1'b0), curV(1'b0))) alignD++;
    if (curDec(1'b1) !== decodeSel(1'b1, curH(1'b1), curV(1'b1))) alignS++;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until the selected instance presents count (h,v).
  task automatic applyStimulus(input bit sel, input int h, input int v,
                               input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (curH(sel) == h && curV(sel) == v) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    int k, low;

    defVecs[0] = '{95,  0, 3'b000};
    defVecs[1] = '{96,  0, 3'b010};
    defVecs[2] = '{143, 0, 3'b010};
    defVecs[3] = '{144, 0, 3'b010};
    defVecs[4] = '{783, 0, 3'b010};
    defVecs[5] = '{799, 0, 3'b010};
    defVecs[6] = '{0,   1, 3'b000};
    defVecs[7] = '{96,  1, 3'b010};
    defVecs[8] = '{0,   2, 3'b001};
    defVecs[9] = '{144, 2, 3'b011};

    smallVecs[0] = '{0,  1,  3'b000};
    smallVecs[1] = '{0,  2,  3'b001};
    smallVecs[2] = '{5,  2,  3'b011};
    smallVecs[3] = '{4,  3,  3'b011};
    smallVecs[4] = '{5,  3,  3'b111};
    smallVecs[5] = '{2,  5,  3'b001};
    smallVecs[6] = '{3,  5,  3'b011};
    smallVecs[7] = '{16, 9,  3'b111};
    smallVecs[8] = '{17, 9,  3'b011};
    smallVecs[9] = '{5,  10, 3'b011};

    // Reset held for 10 clks: everything low.
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("reset_default", int'(dutVec(1'b0)), 0);
    checkOutput("reset_small", int'(dutVec(1'b1)), 0);

    // Release between edges; first pix_en after the 4th rising edge.
    #1 rst = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (ifD.pix_en) break;
    end
    checkOutput("first_pix_en_edge", k, 4);
    @(negedge clk);
    checkOutput("pix_en_one_wide", int'(ifD.pix_en), 0);
    repeat (3) @(negedge clk);
    checkOutput("pix_en_period", int'(ifD.pix_en), 1);

    // Default-timing points along lines 0..2.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, defVecs[i].h, defVecs[i].v, 4000, found);
      checkOutput($sformatf("def_reach_%0d_%0d", defVecs[i].h, defVecs[i].v), int'(found), 1);
      checkOutput($sformatf("def_decode_%0d_%0d", defVecs[i].h, defVecs[i].v),
                  int'(curDec(1'b0)), int'(defVecs[i].exp));
    end

    // hSync low clocks over exactly one line, starting at a line start.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (ifD.pix_en && ifD.hCount == 10'd0) found = 1'b1;
    end
    checkOutput("line_start_reach", int'(found), 1);
    low = (ifD.hSync == 1'b0) ? 1 : 0;
    for (int i = 1; i < D_HT * DIV; i++) begin
      @(negedge clk);
      if (ifD.hSync == 1'b0) low++;
    end
    checkOutput("hsync_low_clks", low, D_HS * DIV);

    // Shrunken-raster points covering visible and sync boundaries.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, smallVecs[i].h, smallVecs[i].v, 2 * S_FRAME, found);
      checkOutput($sformatf("small_reach_%0d_%0d", smallVecs[i].h, smallVecs[i].v), int'(found), 1);
      checkOutput($sformatf("small_decode_%0d_%0d", smallVecs[i].h, smallVecs[i].v),
                  int'(curDec(1'b1)), int'(smallVecs[i].exp));
    end

    // Frame tick: coincidence, period, width and vSync low time.
    found = 1'b0;
    for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
      @(negedge clk);
      if (ifS.frame_tick) found = 1'b1;
    end
    checkOutput("frame_tick_reach", int'(found), 1);
    checkOutput("frame_tick_coincide", int'({ifS.pix_en, ifS.hCount, ifS.vCount}), 1 << 20);
    k = 0;
    low = 0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      @(negedge clk);
      k++;
      if (ifS.vSync == 1'b0) low++;
      if (ifS.frame_tick) break;
    end
    checkOutput("frame_period_clks", k, S_FRAME);
    checkOutput("vsync_low_clks", low, S_VS * S_HT * DIV);
    @(negedge clk);
    checkOutput("frame_tick_width", int'(ifS.frame_tick), 0);

    // Asynchronous reset mid-frame, asserted between edges.
    applyStimulus(1'b1, 10, 6, 2 * S_FRAME, found);
    checkOutput("midframe_reach", int'(found), 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("async_reset_small", int'(dutVec(1'b1)), 0);
    checkOutput("async_reset_default", int'(dutVec(1'b0)), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      @(negedge clk);
      k++;
      if (ifS.frame_tick) break;
    end
    checkOutput("tick_after_reset_clks", k, S_FRAME);
    repeat (8) @(negedge clk);

    checkOutput("model_default", errD, 0);
    checkOutput("model_small", errS, 0);
    checkOutput("align_default", alignD, 0);
    checkOutput("align_small", alignS, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
